frag_queue_write: RTL and testbench
===================================

FRAG_QUEUE_WRITE -- requirements
Module: frag_queue_write

Interface
REQ-001 SHALL have port: i_clk  input  1  system clock, all logic on rising edge.
REQ-002 SHALL have port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: i_frag_wr  input  1  one-cycle strobe, fragment descriptor valid.
REQ-004 SHALL have port: iv_frag_flowid  input  14  flow id of fragment.
REQ-005 SHALL have port: iv_frag_seq  input  4  fragment index within packet, 0..15.
REQ-006 SHALL have port: i_frag_last  input  1  fragment is last of packet.
REQ-007 SHALL have port: iv_frag_bufid  input  9  buffer id holding fragment.
REQ-008 SHALL have port: o_queue_ram_wr  output  1  queue RAM write strobe.
REQ-009 SHALL have port: ov_queue_ram_waddr  output  9  RAM address {qid[4:0], seq[3:0]}.
REQ-010 SHALL have port: ov_queue_ram_wdata  output  10  {last_flag, bufid[8:0]}.
REQ-011 SHALL have port: ov_queue_empty  output  32  bit q = 0 means queue q holds a complete packet ready to read.
REQ-012 SHALL have port: iv_queue_id_free  input  5  queue id returned by the downstream reader.
REQ-013 SHALL have port: i_queue_id_free_wr  input  1  one-cycle strobe for iv_queue_id_free.
REQ-014 SHALL have port: o_drop_bufid_wr  output  1  one-cycle strobe, fragment discarded.
REQ-015 SHALL have port: ov_drop_bufid  output  9  bufid of discarded fragment, for release.

Function
REQ-016 SHALL keep per queue (32): valid bit, 14-bit flowid tag, 16-bit received bitmap, 4-bit last_seq, last_known bit; plus 32-bit free bitmap (1 = free).
REQ-017 SHALL, on i_frag_wr, compare iv_frag_flowid against all valid tags in the same cycle (hit = valid and tag equal).
REQ-018 SHALL, on hit, select the matching qid; on miss, allocate the lowest-numbered free qid, clear its free bit, set valid, load tag, clear bitmap and last_known, all at the same edge.
REQ-019 SHALL, on miss with no free qid, discard: o_drop_bufid_wr=1, ov_drop_bufid=bufid one cycle after i_frag_wr; no RAM write, no state change.
REQ-020 SHALL, on hit with bitmap[seq] already 1 (duplicate), discard per REQ-019.
REQ-021 SHALL otherwise drive o_queue_ram_wr=1, waddr={qid,seq}, wdata={i_frag_last,bufid} for exactly one cycle, one cycle after i_frag_wr (latency 1), and set bitmap[seq].
REQ-022 SHALL, when i_frag_last, record last_seq=seq and set last_known.
REQ-023 SHALL declare queue complete when last_known and bitmap == (2^(last_seq+1))-1, using the updated bitmap; ov_queue_empty[qid] SHALL drop to 0 two cycles after the completing i_frag_wr (one cycle after its RAM write).
REQ-024 SHALL, on completion, clear valid of that queue so a later fragment of the same flow allocates a new queue; free bit stays 0.
REQ-025 SHALL, on i_queue_id_free_wr, set free bit and ov_queue_empty bit of iv_queue_id_free to 1 and clear its bitmap/last_known; free of an already-free qid SHALL be ignored.
REQ-026 SHALL accept i_frag_wr every cycle; back-to-back fragments of a new flow SHALL hit the queue allocated by the preceding one.
REQ-027 SHALL, on simultaneous free and allocation, allocate from the pre-free bitmap; the freed qid is allocatable from the next cycle.
REQ-028 SHALL ignore fragments of a flow whose seq exceeds a known last_seq by discarding per REQ-019.
REQ-029 SHALL never drive o_queue_ram_wr and o_drop_bufid_wr in the same cycle.

Reset
REQ-030 SHALL, on i_rst_n low, immediately set: all queues free and invalid, bitmaps 0, ov_queue_empty=32'hFFFF_FFFF, o_queue_ram_wr=0, ov_queue_ram_waddr=0, ov_queue_ram_wdata=0, o_drop_bufid_wr=0, ov_drop_bufid=0.
REQ-031 SHALL, on reset mid-packet, discard all partial queues; no output pulses until first i_frag_wr after release.

Verification
REQ-032 In-order: flow 0x12 seq 0,1,2(last) bufids 5,6,7 -> writes addr 0x000,0x001,0x002 data 0x005,0x006,0x207; ov_queue_empty[0]=0 two cycles after seq 2.
REQ-033 Out-of-order: flow 0x3 seq 2(last),0,1 -> empty bit stays 1 until seq 1 written, then clears; second flow 0x4 allocated qid 1.
REQ-034 Duplicate: flow 0x12 seq 0 twice, bufids 8,9 -> one write, then o_drop_bufid_wr with bufid 9.
REQ-035 Exhaustion: 32 distinct incomplete flows then a 33rd -> drop pulse; free qid 7 -> next new flow allocated qid 7.
REQ-036 Same-cycle free of qid 0 and new flow with qids 1..31 busy -> drop; next-cycle new flow -> qid 0, ov_queue_empty[0]=1 after free.
REQ-037 Assert reset mid-packet -> all outputs at reset values; queue 0 reusable.

Source files
------------

// File: rtl/frag_queue_write_if.sv
// Bundle of fragment-in, queue-RAM-write, drop-release and queue-free signals for frag_queue_write.
// The master side is the upstream/downstream environment; the slave side is the queue writer.
interface frag_queue_write_if;
    logic        i_frag_wr;
    logic [13:0] iv_frag_flowid;
    logic [3:0]  iv_frag_seq;
    logic        i_frag_last;
    logic [8:0]  iv_frag_bufid;
    logic        o_queue_ram_wr;
    logic [8:0]  ov_queue_ram_waddr;
    logic [9:0]  ov_queue_ram_wdata;
    logic [31:0] ov_queue_empty;
    logic [4:0]  iv_queue_id_free;
    logic        i_queue_id_free_wr;
    logic        o_drop_bufid_wr;
    logic [8:0]  ov_drop_bufid;

    modport master (
        output i_frag_wr, iv_frag_flowid, iv_frag_seq, i_frag_last, iv_frag_bufid,
        output iv_queue_id_free, i_queue_id_free_wr,
        input  o_queue_ram_wr, ov_queue_ram_waddr, ov_queue_ram_wdata, ov_queue_empty,
        input  o_drop_bufid_wr, ov_drop_bufid
    );

    modport slave (
        input  i_frag_wr, iv_frag_flowid, iv_frag_seq, i_frag_last, iv_frag_bufid,
        input  iv_queue_id_free, i_queue_id_free_wr,
        output o_queue_ram_wr, ov_queue_ram_waddr, ov_queue_ram_wdata, ov_queue_empty,
        output o_drop_bufid_wr, ov_drop_bufid
    );
endinterface

// File: rtl/frag_queue_write.sv
// Reassembly queue writer: maps fragments to per-flow queues, writes them into the queue RAM,
// and flags a queue non-empty once every fragment up to the last one has arrived.
module frag_queue_write (
    input  logic             i_clk,
    input  logic             i_rst_n,
    frag_queue_write_if.slave bus
);

    logic [31:0] valid_q, valid_d;
    logic [31:0] free_q, free_d;
    logic [31:0] empty_q, empty_d;
    logic [31:0] last_known_q, last_known_d;
    logic [13:0] tag_q [32];
    logic [13:0] tag_d [32];
    logic [15:0] bitmap_q [32];
    logic [15:0] bitmap_d [32];
    logic [3:0]  last_seq_q [32];
    logic [3:0]  last_seq_d [32];

    logic        ram_wr_q, ram_wr_d;
    logic [8:0]  ram_waddr_q, ram_waddr_d;
    logic [9:0]  ram_wdata_q, ram_wdata_d;
    logic        drop_wr_q, drop_wr_d;
    logic [8:0]  drop_bufid_q, drop_bufid_d;
    logic        complete_q, complete_d;
    logic [4:0]  complete_qid_q, complete_qid_d;

    logic [31:0] hit_vec;
    logic        hit;
    logic [4:0]  hit_qid;
    logic        any_free;
    logic [4:0]  alloc_qid;
    logic [4:0]  sel_qid;
    logic [15:0] base_bm;
    logic        base_lk;
    logic [3:0]  base_ls;
    logic        reject;
    logic [15:0] new_bm;
    logic        new_lk;
    logic [3:0]  new_ls;
    logic [15:0] done_mask;
    logic        done;

    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i[4:0];
        end
        return idx;
    endfunction

    // Tag lookup and candidate update for the incoming fragment, independent of the strobe.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            hit_vec[i] = valid_q[i] && (tag_q[i] == bus.iv_frag_flowid);
        end
        hit       = |hit_vec;
        hit_qid   = lowest_set(hit_vec);
        any_free  = |free_q;
        alloc_qid = lowest_set(free_q);
        sel_qid   = hit ? hit_qid : alloc_qid;
        base_bm   = hit ? bitmap_q[hit_qid] : 16'h0000;
        base_lk   = hit ? last_known_q[hit_qid] : 1'b0;
        base_ls   = hit ? last_seq_q[hit_qid] : 4'd0;
        reject    = hit ? (base_bm[bus.iv_frag_seq] || (base_lk && (bus.iv_frag_seq > base_ls)))
                        : !any_free;
        new_bm    = base_bm | (16'h0001 << bus.iv_frag_seq);
        new_lk    = base_lk | bus.i_frag_last;
        new_ls    = bus.i_frag_last ? bus.iv_frag_seq : base_ls;
        done_mask = 16'hFFFF >> (4'd15 - new_ls);
        done      = new_lk && (new_bm == done_mask);
    end

    always_comb begin
        valid_d        = valid_q;
        free_d         = free_q;
        empty_d        = empty_q;
        last_known_d   = last_known_q;
        tag_d          = tag_q;
        bitmap_d       = bitmap_q;
        last_seq_d     = last_seq_q;
        ram_wr_d       = 1'b0;
        ram_waddr_d    = ram_waddr_q;
        ram_wdata_d    = ram_wdata_q;
        drop_wr_d      = 1'b0;
        drop_bufid_d   = drop_bufid_q;
        complete_d     = 1'b0;
        complete_qid_d = complete_qid_q;

        if (complete_q) empty_d[complete_qid_q] = 1'b0;

        if (bus.i_frag_wr) begin
            if (reject) begin
                drop_wr_d    = 1'b1;
                drop_bufid_d = bus.iv_frag_bufid;
            end else begin
                // A completed queue leaves the tag table so the flow's next packet gets a fresh queue.
                valid_d[sel_qid]      = !done;
                free_d[sel_qid]       = 1'b0;
                tag_d[sel_qid]        = bus.iv_frag_flowid;
                bitmap_d[sel_qid]     = new_bm;
                last_known_d[sel_qid] = new_lk;
                last_seq_d[sel_qid]   = new_ls;
                ram_wr_d              = 1'b1;
                ram_waddr_d           = {sel_qid, bus.iv_frag_seq};
                ram_wdata_d           = {bus.i_frag_last, bus.iv_frag_bufid};
                complete_d            = done;
                complete_qid_d        = sel_qid;
            end
        end

        // Allocation above used the pre-free bitmap; the release lands last so it wins.
        if (bus.i_queue_id_free_wr && !free_q[bus.iv_queue_id_free]) begin
            free_d[bus.iv_queue_id_free]       = 1'b1;
            empty_d[bus.iv_queue_id_free]      = 1'b1;
            valid_d[bus.iv_queue_id_free]      = 1'b0;
            bitmap_d[bus.iv_queue_id_free]     = 16'h0000;
            last_known_d[bus.iv_queue_id_free] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q        <= '0;
            free_q         <= '1;
            empty_q        <= '1;
            last_known_q   <= '0;
            for (int i = 0; i < 32; i++) begin
                tag_q[i]      <= '0;
                bitmap_q[i]   <= '0;
                last_seq_q[i] <= '0;
            end
            ram_wr_q       <= 1'b0;
            ram_waddr_q    <= '0;
            ram_wdata_q    <= '0;
            drop_wr_q      <= 1'b0;
            drop_bufid_q   <= '0;
            complete_q     <= 1'b0;
            complete_qid_q <= '0;
        end else begin
            valid_q        <= valid_d;
            free_q         <= free_d;
            empty_q        <= empty_d;
            last_known_q   <= last_known_d;
            tag_q          <= tag_d;
            bitmap_q       <= bitmap_d;
            last_seq_q     <= last_seq_d;
            ram_wr_q       <= ram_wr_d;
            ram_waddr_q    <= ram_waddr_d;
            ram_wdata_q    <= ram_wdata_d;
            drop_wr_q      <= drop_wr_d;
            drop_bufid_q   <= drop_bufid_d;
            complete_q     <= complete_d;
            complete_qid_q <= complete_qid_d;
        end
    end

    assign bus.o_queue_ram_wr     = ram_wr_q;
    assign bus.ov_queue_ram_waddr = ram_waddr_q;
    assign bus.ov_queue_ram_wdata = ram_wdata_q;
    assign bus.ov_queue_empty     = empty_q;
    assign bus.o_drop_bufid_wr    = drop_wr_q;
    assign bus.ov_drop_bufid      = drop_bufid_q;

endmodule

// File: tb/tb_frag_queue_write.sv
// Scoreboard bench for frag_queue_write: directed fragments push expected RAM writes / drops,
// and a negedge monitor pops and compares every output pulse.
module tb_frag_queue_write;

    logic clk;
    logic rst_n;

    frag_queue_write_if bus();

    frag_queue_write dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic       isDrop;
        logic [8:0] addr;
        logic [9:0] data;
    } exp_t;

    exp_t expQ[$];
    int checkCount = 0;
    int passCount  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    // Drives one fragment for exactly one cycle and records the response it must produce.
    task automatic applyStimulus(input logic [13:0] flow, input logic [3:0] seq, input logic last,
                                 input logic [8:0] bufid, input logic isDrop, input logic [4:0] qid);
        exp_t e;
        e.isDrop = isDrop;
        e.addr   = isDrop ? 9'h000 : {qid, seq};
        e.data   = isDrop ? {1'b0, bufid} : {last, bufid};
        expQ.push_back(e);
        bus.i_frag_wr      = 1'b1;
        bus.iv_frag_flowid = flow;
        bus.iv_frag_seq    = seq;
        bus.i_frag_last    = last;
        bus.iv_frag_bufid  = bufid;
        @(posedge clk);
        #1;
        bus.i_frag_wr = 1'b0;
    endtask

    task automatic freeQueue(input logic [4:0] qid);
        bus.iv_queue_id_free   = qid;
        bus.i_queue_id_free_wr = 1'b1;
        @(posedge clk);
        #1;
        bus.i_queue_id_free_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_empty"},      bus.ov_queue_empty, 32'hFFFF_FFFF);
        checkOutput({tag, "_ram_wr"},     {31'h0, bus.o_queue_ram_wr}, 32'h0);
        checkOutput({tag, "_waddr"},      {23'h0, bus.ov_queue_ram_waddr}, 32'h0);
        checkOutput({tag, "_wdata"},      {22'h0, bus.ov_queue_ram_wdata}, 32'h0);
        checkOutput({tag, "_drop_wr"},    {31'h0, bus.o_drop_bufid_wr}, 32'h0);
        checkOutput({tag, "_drop_bufid"}, {23'h0, bus.ov_drop_bufid}, 32'h0);
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.o_queue_ram_wr && bus.o_drop_bufid_wr) begin
                checkCount++;
                $display("[TB] FAIL wr_and_drop: got both strobes high expected at most one");
            end
            if (bus.o_queue_ram_wr || bus.o_drop_bufid_wr) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected_pulse: got wr=%0b drop=%0b expected none",
                             bus.o_queue_ram_wr, bus.o_drop_bufid_wr);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pulse_is_drop", {31'h0, bus.o_drop_bufid_wr}, {31'h0, e.isDrop});
                    if (e.isDrop) begin
                        checkOutput("drop_bufid", {23'h0, bus.ov_drop_bufid}, {22'h0, e.data} & 32'h1FF);
                    end else begin
                        checkOutput("ram_waddr", {23'h0, bus.ov_queue_ram_waddr}, {23'h0, e.addr});
                        checkOutput("ram_wdata", {22'h0, bus.ov_queue_ram_wdata}, {22'h0, e.data});
                    end
                end
            end
        end
    end

    initial begin
        rst_n                  = 1'b0;
        bus.i_frag_wr          = 1'b0;
        bus.iv_frag_flowid     = '0;
        bus.iv_frag_seq        = '0;
        bus.i_frag_last        = 1'b0;
        bus.iv_frag_bufid      = '0;
        bus.iv_queue_id_free   = '0;
        bus.i_queue_id_free_wr = 1'b0;
        #12;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // In-order packet, flow 0x12 -> qid 0
        applyStimulus(14'h12, 4'd0, 1'b0, 9'd5, 1'b0, 5'd0);
        applyStimulus(14'h12, 4'd1, 1'b0, 9'd6, 1'b0, 5'd0);
        applyStimulus(14'h12, 4'd2, 1'b1, 9'd7, 1'b0, 5'd0);
        checkOutput("inorder_empty0_early", {31'h0, bus.ov_queue_empty[0]}, 32'h1);
        idle(1);
        checkOutput("inorder_empty0_done", {31'h0, bus.ov_queue_empty[0]}, 32'h0);

        // Duplicate: completed flow 0x12 restarts in qid 1, repeated seq 0 is dropped
        applyStimulus(14'h12, 4'd0, 1'b0, 9'd8, 1'b0, 5'd1);
        applyStimulus(14'h12, 4'd0, 1'b0, 9'd9, 1'b1, 5'd0);

        // Out-of-order: flow 0x3 in qid 2 completes only when seq 1 arrives
        applyStimulus(14'h3, 4'd2, 1'b1, 9'h20, 1'b0, 5'd2);
        applyStimulus(14'h3, 4'd0, 1'b0, 9'h21, 1'b0, 5'd2);
        idle(2);
        checkOutput("ooo_empty2_partial", {31'h0, bus.ov_queue_empty[2]}, 32'h1);
        applyStimulus(14'h3, 4'd1, 1'b0, 9'h22, 1'b0, 5'd2);
        idle(1);
        checkOutput("ooo_empty2_done", {31'h0, bus.ov_queue_empty[2]}, 32'h0);
        applyStimulus(14'h4, 4'd0, 1'b0, 9'h30, 1'b0, 5'd3);

        // Fragment beyond a known last seq is dropped
        applyStimulus(14'h5, 4'd2, 1'b1, 9'h40, 1'b0, 5'd4);
        applyStimulus(14'h5, 4'd3, 1'b0, 9'h41, 1'b1, 5'd0);

        freeQueue(5'd0);
        checkOutput("free_empty0", {31'h0, bus.ov_queue_empty[0]}, 32'h1);
        freeQueue(5'd2);
        checkOutput("free_empty2", {31'h0, bus.ov_queue_empty[2]}, 32'h1);

        // Exhaustion: fill every free qid (all but 1, 3, 4), then one more flow is dropped
        for (int q = 0; q < 32; q++) begin
            if (q != 1 && q != 3 && q != 4)
                applyStimulus(14'h100 + 14'(q), 4'd0, 1'b0, 9'(q), 1'b0, 5'(q));
        end
        applyStimulus(14'h200, 4'd0, 1'b0, 9'h1FF, 1'b1, 5'd0);
        freeQueue(5'd7);
        applyStimulus(14'h201, 4'd0, 1'b0, 9'h1AA, 1'b0, 5'd7);

        // Same-cycle free of qid 0 and a new flow: allocation sees the old bitmap
        bus.iv_queue_id_free   = 5'd0;
        bus.i_queue_id_free_wr = 1'b1;
        applyStimulus(14'h300, 4'd0, 1'b0, 9'h0AB, 1'b1, 5'd0);
        bus.i_queue_id_free_wr = 1'b0;
        checkOutput("simfree_empty0", {31'h0, bus.ov_queue_empty[0]}, 32'h1);
        applyStimulus(14'h301, 4'd0, 1'b0, 9'h055, 1'b0, 5'd0);
        applyStimulus(14'h301, 4'd1, 1'b0, 9'h011, 1'b0, 5'd0);
        idle(1);

        // Reset mid-packet: outputs clear immediately, partial queues are forgotten
        rst_n = 1'b0;
        #2;
        checkResetOutputs("midreset");
        idle(1);
        rst_n = 1'b1;
        idle(2);
        applyStimulus(14'h301, 4'd0, 1'b1, 9'h013, 1'b0, 5'd0);
        applyStimulus(14'h500, 4'd0, 1'b0, 9'h014, 1'b0, 5'd1);
        checkOutput("postreset_empty0", {31'h0, bus.ov_queue_empty[0]}, 32'h0);

        idle(3);
        checkOutput("scoreboard_drained", expQ.size(), 32'h0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
